param_instruction_stack: RTL

//  Parametrised LIFO for instruction/operand words feeding the Lisp ALU

---
 rtl/param_instruction_stack.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/param_instruction_stack.sv
// Parametrised LIFO for instruction/operand words with count, flags and overflow/underflow pulses.
// Define STACK_PEEK_EN to add the registered second-entry output next_top.
module param_instruction_stack #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 256,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
`ifdef STACK_PEEK_EN
    output logic [WIDTH-1:0] next_top,
`endif
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
`ifdef STACK_PEEK_EN
    logic [WIDTH-1:0] next_top_q, next_top_d;
    logic [AW-1:0]    rd3_addr;
    logic [WIDTH-1:0] mem_rd3;
`endif

    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd2_addr;
    logic [WIDTH-1:0] mem_rd2;
    logic             cnt_zero, cnt_full;

    assign cnt_zero = (count_q == '0);
    assign cnt_full = (count_q == CW'(DEPTH));

    // Reads are only used when count guarantees the index is in range.
    assign rd2_addr = AW'(count_q - CW'(2));
    assign mem_rd2  = mem[rd2_addr];
`ifdef STACK_PEEK_EN
    assign rd3_addr = AW'(count_q - CW'(3));
    assign mem_rd3  = mem[rd3_addr];
`endif

    always_comb begin
        count_d     = count_q;
        top_d       = top_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        we          = 1'b0;
        wr_addr     = AW'(count_q);
`ifdef STACK_PEEK_EN
        next_top_d  = next_top_q;
`endif
        if (clear) begin
            count_d = '0;
            top_d   = '0;
`ifdef STACK_PEEK_EN
            next_top_d = '0;
`endif
        end else if (push && pop) begin
            // Replace top in place; on an empty stack this degenerates to a push.
            we    = 1'b1;
            top_d = in_data;
            if (cnt_zero) begin
                count_d = CW'(1);
`ifdef STACK_PEEK_EN
                next_top_d = '0;
`endif
            end else begin
                wr_addr = AW'(count_q - CW'(1));
            end
        end else if (push) begin
            if (cnt_full) begin
                overflow_d = 1'b1;
            end else begin
                we      = 1'b1;
                top_d   = in_data;
                count_d = count_q + CW'(1);
`ifdef STACK_PEEK_EN
                next_top_d = cnt_zero ? '0 : top_q;
`endif
            end
        end else if (pop) begin
            if (cnt_zero) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
                top_d   = (count_q >= CW'(2)) ? mem_rd2 : '0;
`ifdef STACK_PEEK_EN
                next_top_d = (count_q >= CW'(3)) ? mem_rd3 : '0;
`endif
            end
        end
    end

    // Storage is not reset; a cleared or reset count hides stale entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            top_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef STACK_PEEK_EN
            next_top_q  <= '0;
`endif
        end else begin
            count_q     <= count_d;
            top_q       <= top_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef STACK_PEEK_EN
            next_top_q  <= next_top_d;
`endif
        end
    end

    assign top       = top_q;
    assign count     = count_q;
    assign empty     = cnt_zero;
    assign full      = cnt_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`ifdef STACK_PEEK_EN
    assign next_top  = next_top_q;
`endif

endmodule
